// File: rtl/dbg_mem_bridge.sv
// SPI debug bridge: READ_WORD / WRITE_WORD host commands mapped onto
// single AXI4-lite transactions, with status and read data returned over SPI.
module dbg_mem_bridge #(
    parameter int          ADDR_W    = 32,
    parameter logic [7:0]  CMD_READ  = 8'h08,
    parameter logic [7:0]  CMD_WRITE = 8'h09
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        recv_data,
    input  logic              recv_ready,
    output logic [7:0]        send_data,
    output logic              active,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_AXI_RD = 3'd3;
    localparam logic [2:0] S_AXI_WR = 3'd4;
    localparam logic [2:0] S_REPLY  = 3'd5;

    localparam logic [7:0] ST_BUSY  = 8'h00;
    localparam logic [7:0] ST_OKAY  = 8'h01;
    localparam logic [7:0] ST_ERR   = 8'h02;
    localparam logic [7:0] ST_ALIGN = 8'h04;

    logic [2:0]        state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        send_q, send_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;

    logic              is_cmd;
    logic [7:0]        reply_byte;

    assign is_cmd = (recv_data == CMD_READ) || (recv_data == CMD_WRITE);

    // Read data leaves MSB first; cnt_q counts the bytes still to send.
    always_comb begin
        case (cnt_q)
            3'd4:    reply_byte = rdata_q[31:24];
            3'd3:    reply_byte = rdata_q[23:16];
            3'd2:    reply_byte = rdata_q[15:8];
            default: reply_byte = rdata_q[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        send_d    = send_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;

        case (state_q)
            S_IDLE: begin
                if (recv_ready && is_cmd) begin
                    op_wr_d = (recv_data == CMD_WRITE);
                    state_d = S_ADDR;
                    cnt_d   = 3'd4;
                    send_d  = ST_BUSY;
                end
            end
            S_ADDR: begin
                if (recv_ready) begin
                    addr_d = {addr_q[ADDR_W-9:0], recv_data};
                    send_d = ST_BUSY;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (recv_data[1:0] != 2'b00) begin
                            send_d  = ST_ALIGN;
                            state_d = S_IDLE;
                        end else if (op_wr_q) begin
                            state_d = S_DATA;
                            cnt_d   = 3'd4;
                        end else begin
                            state_d   = S_AXI_RD;
                            arvalid_d = 1'b1;
                            rready_d  = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (recv_ready) begin
                    wdata_d = {wdata_q[23:0], recv_data};
                    send_d  = ST_BUSY;
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d   = S_AXI_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end
                end
            end
            S_AXI_RD: begin
                if (recv_ready)
                    send_d = ST_BUSY;
                if (arvalid_q && arready)
                    arvalid_d = 1'b0;
                // Status load overrides a coinciding poll byte.
                if (rvalid) begin
                    rdata_d   = rdata;
                    send_d    = (rresp == 2'b00) ? ST_OKAY : ST_ERR;
                    rready_d  = 1'b0;
                    arvalid_d = 1'b0;
                    state_d   = S_REPLY;
                    cnt_d     = 3'd4;
                end
            end
            S_AXI_WR: begin
                if (recv_ready)
                    send_d = ST_BUSY;
                if (awvalid_q && awready)
                    awvalid_d = 1'b0;
                if (wvalid_q && wready)
                    wvalid_d = 1'b0;
                if (bvalid) begin
                    send_d    = (bresp == 2'b00) ? ST_OKAY : ST_ERR;
                    bready_d  = 1'b0;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_REPLY: begin
                if (recv_ready) begin
                    send_d = reply_byte;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_wr_q   <= 1'b0;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            send_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            send_q    <= send_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign active    = (state_q != S_IDLE) ||
                       (recv_ready && is_cmd);
    assign send_data = send_q;
    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign wdata     = wdata_q;
    assign wstrb     = 4'hF;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Directed bench for dbg_mem_bridge: byte-level vector table plus
// hand-written AXI handshake, error, race and reset sequences.
module tb_dbg_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  recv_data;
    logic        recv_ready;
    logic [7:0]  send_data;
    logic        active;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_vec = 0;
    int n_bad = 0;
    int ar_hs = 0;
    int aw_hs = 0;
    int w_hs  = 0;
    int ar_seen = 0;
    logic act_in;

    dbg_mem_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .recv_data(recv_data), .recv_ready(recv_ready),
        .send_data(send_data), .active(active),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arvalid) ar_seen <= ar_seen + 1;
        if (arvalid && arready) ar_hs <= ar_hs + 1;
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready) w_hs <= w_hs + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; pulses one byte, returns at the next negedge.
    task automatic put(input logic [7:0] b);
        recv_data  = b;
        recv_ready = 1'b1;
        #1 act_in = active;
        @(negedge clk);
        recv_ready = 1'b0;
    endtask

    task automatic put_chk(input string name, input logic [7:0] b,
                           input logic [7:0] exp);
        put(b);
        chk(name, {24'd0, send_data}, {24'd0, exp});
    endtask

    typedef struct {
        logic [7:0] b;
        logic [7:0] exp_send;
        logic       exp_act_in;
        logic       exp_act_out;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{8'h08, 8'h00, 1'b1, 1'b1};
        tbl[1]  = '{8'h00, 8'h00, 1'b1, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 1'b1, 1'b1};
        tbl[3]  = '{8'h00, 8'h00, 1'b1, 1'b1};
        tbl[4]  = '{8'h13, 8'h04, 1'b1, 1'b0};
        tbl[5]  = '{8'h02, 8'h04, 1'b0, 1'b0};
        tbl[6]  = '{8'h05, 8'h04, 1'b0, 1'b0};
        tbl[7]  = '{8'h07, 8'h04, 1'b0, 1'b0};
        tbl[8]  = '{8'h09, 8'h00, 1'b1, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b1};
        tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b1};
        tbl[11] = '{8'h01, 8'h00, 1'b1, 1'b1};
        tbl[12] = '{8'h00, 8'h00, 1'b1, 1'b1};
        tbl[13] = '{8'hCA, 8'h00, 1'b1, 1'b1};
        tbl[14] = '{8'hFE, 8'h00, 1'b1, 1'b1};
        tbl[15] = '{8'hBA, 8'h00, 1'b1, 1'b1};
        tbl[16] = '{8'hBE, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; recv_data = 8'h00; recv_ready = 1'b0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        act_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_send", {24'd0, send_data}, 32'h0);
        chk("rst_active", {31'd0, active}, 32'h0);
        chk("rst_valids", {28'd0, arvalid, awvalid, wvalid, rready},
            32'h0);
        chk("rst_bready", {31'd0, bready}, 32'h0);
        chk("rst_addr", araddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);

        // Misaligned read, foreign bytes, then write command bytes.
        for (int i = 0; i < 17; i++) begin
            put(tbl[i].b);
            chk($sformatf("vec%0d_send", i), {24'd0, send_data},
                {24'd0, tbl[i].exp_send});
            chk($sformatf("vec%0d_act_in", i), {31'd0, act_in},
                {31'd0, tbl[i].exp_act_in});
            chk($sformatf("vec%0d_act_out", i), {31'd0, active},
                {31'd0, tbl[i].exp_act_out});
            if (i == 7)
                chk("misalign_no_ar", ar_seen, 0);
        end

        // Write: awready one cycle ahead of wready.
        chk("wr_awvalid", {31'd0, awvalid}, 32'h1);
        chk("wr_wvalid", {31'd0, wvalid}, 32'h1);
        chk("wr_bready", {31'd0, bready}, 32'h1);
        chk("wr_awaddr", awaddr, 32'h100);
        chk("wr_wdata", wdata, 32'hCAFEBABE);
        chk("wr_wstrb", {28'd0, wstrb}, 32'hF);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        chk("wr_aw_drop", {31'd0, awvalid}, 32'h0);
        chk("wr_w_hold", {31'd0, wvalid}, 32'h1);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        chk("wr_w_drop", {31'd0, wvalid}, 32'h0);
        put_chk("wr_poll", 8'h33, 8'h00);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        chk("wr_status", {24'd0, send_data}, 32'h01);
        chk("wr_idle", {31'd0, active}, 32'h0);
        chk("wr_bready_drop", {31'd0, bready}, 32'h0);
        chk("wr_aw_hs", aw_hs, 1);
        chk("wr_w_hs", w_hs, 1);

        // Read OKAY with a poll racing rvalid.
        put(8'h08); put(8'h00); put(8'h00); put(8'h00); put(8'h10);
        chk("rd_arvalid", {31'd0, arvalid}, 32'h1);
        chk("rd_rready", {31'd0, rready}, 32'h1);
        chk("rd_araddr", araddr, 32'h10);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("rd_ar_drop", {31'd0, arvalid}, 32'h0);
        put_chk("rd_poll", 8'h00, 8'h00);
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        put(8'h00);
        rvalid = 1'b0; rdata = 32'h0;
        chk("rd_race_status", {24'd0, send_data}, 32'h01);
        chk("rd_rready_drop", {31'd0, rready}, 32'h0);
        put_chk("rd_b3", 8'h00, 8'hDE);
        put_chk("rd_b2", 8'h00, 8'hAD);
        put_chk("rd_b1", 8'h00, 8'hBE);
        chk("rd_act_mid", {31'd0, active}, 32'h1);
        put_chk("rd_b0", 8'h00, 8'hEF);
        chk("rd_act_end", {31'd0, active}, 32'h0);
        chk("rd_ar_hs", ar_hs, 1);

        // Read returning SLVERR: status 02, data still sent.
        put(8'h08); put(8'h00); put(8'h00); put(8'h00); put(8'h20);
        chk("err_araddr", araddr, 32'h20);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00;
        chk("err_status", {24'd0, send_data}, 32'h02);
        put_chk("err_b3", 8'h00, 8'h12);
        put_chk("err_b2", 8'h00, 8'h34);
        put_chk("err_b1", 8'h00, 8'h56);
        put_chk("err_b0", 8'h00, 8'h78);
        chk("err_act_end", {31'd0, active}, 32'h0);

        // Reset while arvalid is pending.
        put(8'h08); put(8'h00); put(8'h00); put(8'h00); put(8'h30);
        chk("rst_mid_arvalid_pre", {31'd0, arvalid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_arvalid", {31'd0, arvalid}, 32'h0);
        chk("rst_mid_rready", {31'd0, rready}, 32'h0);
        chk("rst_mid_active", {31'd0, active}, 32'h0);
        chk("rst_mid_send", {24'd0, send_data}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
